// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad scanner and its key-event FIFO.
package keypad_pkg;

  localparam int default_row_number    = 4;
  localparam int default_column_number = 4;

  // Width of a key code that addresses every cell of the matrix.
  function automatic int code_width_f(input int rows, input int columns);
    return (rows * columns > 1) ? $clog2(rows * columns) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } keypad_state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_class_t;

endpackage

// File: rtl/keypad_fifo.sv
// Small synchronous FIFO carrying accepted key codes; the head entry is always visible.
module keypad_fifo
  import keypad_pkg::*;
#(
  parameter int data_width = 4,
  parameter int depth      = 4
) (
  input  logic                  clock_digital_tube,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [data_width-1:0] push_data,
  output logic [data_width-1:0] head,
  output logic                  full,
  output logic                  empty
);

  localparam int ptr_width = (depth > 1) ? $clog2(depth) : 1;

  logic [data_width-1:0] mem_reg [depth];
  logic [ptr_width-1:0]  wr_ptr_reg;
  logic [ptr_width-1:0]  rd_ptr_reg;
  logic [ptr_width:0]    count_reg;
  logic                  push_fire;
  logic                  pop_fire;

  assign full      = (count_reg == (ptr_width + 1)'(depth));
  assign empty     = (count_reg == '0);
  assign pop_fire  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_fire = push && (!full || pop_fire);
  assign head      = mem_reg[rd_ptr_reg];

  always_ff @(posedge clock_digital_tube or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < depth; i++) begin
        mem_reg[ptr_width'(i)] <= '0;
      end
    end else if (push_fire) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clock_digital_tube or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_fire, pop_fire})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Column-strobed keypad scanner: synchronizes rows, snapshots whole frames,
// debounces over frames and queues one code per accepted press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int   row_number      = default_row_number,
  parameter int   column_number   = default_column_number,
  parameter int   column_dwell    = 4,
  parameter int   debounce_frames = 4,
  parameter int   fifo_depth      = 4,
  localparam int  code_width      = code_width_f(row_number, column_number)
) (
  input  logic                     clock_digital_tube,
  input  logic                     reset_n,
  input  logic [row_number-1:0]    row_n,
  output logic [column_number-1:0] column_n,
  output logic [code_width-1:0]    key_code,
  output logic                     key_valid,
  input  logic                     key_ready,
  output logic                     key_held,
  output logic                     overflow
);

  localparam int row_width    = (row_number > 1) ? $clog2(row_number) : 1;
  localparam int column_width = (column_number > 1) ? $clog2(column_number) : 1;
  localparam int dwell_width  = $clog2(column_dwell);
  localparam int count_width  = $clog2(debounce_frames + 1);

  logic [row_number-1:0]   row_sync1_reg;
  logic [row_number-1:0]   row_sync2_reg;
  logic [column_width-1:0] column_index_reg;
  logic [dwell_width-1:0]  dwell_count_reg;
  logic [row_number-1:0]   frame_reg [column_number];
  logic                    frame_valid_reg;
  logic                    sample_en;
  logic                    last_column;

  frame_class_t            frame_class;
  logic [code_width-1:0]   frame_code;

  keypad_state_t           state_reg;
  keypad_state_t           state_next;
  logic [count_width-1:0]  count_reg;
  logic [count_width-1:0]  count_next;
  logic [code_width-1:0]   candidate_reg;
  logic [code_width-1:0]   candidate_next;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    overflow_reg;

  always_ff @(posedge clock_digital_tube or negedge reset_n) begin
    if (!reset_n) begin
      row_sync1_reg <= '1;
      row_sync2_reg <= '1;
    end else begin
      row_sync1_reg <= row_n;
      row_sync2_reg <= row_sync1_reg;
    end
  end

  assign sample_en   = (dwell_count_reg == dwell_width'(column_dwell - 1));
  assign last_column = (column_index_reg == column_width'(column_number - 1));

  always_ff @(posedge clock_digital_tube or negedge reset_n) begin
    if (!reset_n) begin
      column_index_reg <= '0;
      dwell_count_reg  <= '0;
    end else if (sample_en) begin
      dwell_count_reg  <= '0;
      column_index_reg <= last_column ? '0 : column_index_reg + 1'b1;
    end else begin
      dwell_count_reg  <= dwell_count_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < column_number; gi++) begin : g_strobe
    assign column_n[gi] = (column_index_reg != column_width'(gi));
  end

  // Sampling on the last dwell cycle leaves two cycles for the synchronizer to settle.
  always_ff @(posedge clock_digital_tube or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < column_number; c++) begin
        frame_reg[column_width'(c)] <= '0;
      end
      frame_valid_reg <= 1'b0;
    end else begin
      if (sample_en) begin
        frame_reg[column_index_reg] <= ~row_sync2_reg;
      end
      frame_valid_reg <= sample_en && last_column;
    end
  end

  always_comb begin
    logic seen_one;
    logic seen_two;
    seen_one   = 1'b0;
    seen_two   = 1'b0;
    frame_code = '0;
    for (int r = 0; r < row_number; r++) begin
      for (int c = 0; c < column_number; c++) begin
        if (frame_reg[column_width'(c)][row_width'(r)]) begin
          if (seen_one) begin
            seen_two = 1'b1;
          end else begin
            seen_one   = 1'b1;
            frame_code = code_width'(r * column_number + c);
          end
        end
      end
    end
    if (seen_two) begin
      frame_class = MULTI;
    end else if (seen_one) begin
      frame_class = SINGLE;
    end else begin
      frame_class = NONE;
    end
  end

  always_ff @(posedge clock_digital_tube or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      candidate_reg <= '0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      candidate_reg <= candidate_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    candidate_next = candidate_reg;
    push           = 1'b0;
    if (frame_valid_reg) begin
      case (state_reg)
        IDLE: begin
          if (frame_class == SINGLE) begin
            candidate_next = frame_code;
            count_next     = count_width'(1);
            state_next     = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (frame_class == SINGLE && frame_code == candidate_reg) begin
            if (count_reg + 1'b1 == count_width'(debounce_frames)) begin
              push       = 1'b1;
              count_next = '0;
              state_next = HELD;
            end else begin
              count_next = count_reg + 1'b1;
            end
          end else if (frame_class == SINGLE) begin
            candidate_next = frame_code;
            count_next     = count_width'(1);
          end else begin
            count_next = '0;
            state_next = IDLE;
          end
        end
        HELD: begin
          // Chords and held keys keep the state; there is no auto-repeat.
          if (frame_class == NONE) begin
            count_next = count_width'(1);
            state_next = RELEASE;
          end
        end
        RELEASE: begin
          if (frame_class == NONE) begin
            if (count_reg + 1'b1 == count_width'(debounce_frames)) begin
              count_next = '0;
              state_next = IDLE;
            end else begin
              count_next = count_reg + 1'b1;
            end
          end else begin
            count_next = '0;
            state_next = HELD;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign key_held  = (state_reg == HELD) || (state_reg == RELEASE);
  assign key_valid = !fifo_empty;
  assign pop       = key_valid && key_ready;

  keypad_fifo #(
    .data_width (code_width),
    .depth      (fifo_depth)
  ) u_fifo (
    .clock_digital_tube (clock_digital_tube),
    .reset_n            (reset_n),
    .push               (push),
    .pop                (pop),
    .push_data          (candidate_reg),
    .head               (key_code),
    .full               (fifo_full),
    .empty              (fifo_empty)
  );

  always_ff @(posedge clock_digital_tube or negedge reset_n) begin
    if (!reset_n) begin
      overflow_reg <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow_reg <= 1'b1;
    end
  end

  assign overflow = overflow_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: models the key matrix and checks events per scenario.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  column_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready = 1'b1;
  logic        key_held;
  logic        overflow;
  logic [15:0] keys_down = '0;
  logic [3:0]  ev_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  keypad_scanner dut (
    .clock_digital_tube (clk),
    .reset_n            (reset_n),
    .row_n              (row_n),
    .column_n           (column_n),
    .key_code           (key_code),
    .key_valid          (key_valid),
    .key_ready          (key_ready),
    .key_held           (key_held),
    .overflow           (overflow)
  );

  always #5 clk = ~clk;

  // Key matrix: a closed key pulls its row low while its column is strobed.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys_down[4'(r * 4 + c)] && !column_n[2'(c)]) begin
          row_n[2'(r)] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && key_valid && key_ready) begin
      ev_q.push_back(key_code);
      $display("event: key_code=%0d at time %0t", key_code, $time);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_frames(input int n);
    repeat (n * 16) tick();
  endtask

  task automatic test_reset();
    logic [3:0] one;
    logic [3:0] exp_col;
    one       = 4'b0001;
    reset_n   = 1'b0;
    keys_down = '0;
    key_ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({column_n, key_valid, key_held, overflow, key_code} !== 11'b1110_000_0000) begin
      n_fail++;
      $display("FAIL reset_state: got col=%b v=%b h=%b o=%b code=%0d, want col=1110 v=0 h=0 o=0 code=0",
               column_n, key_valid, key_held, overflow, key_code);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      exp_col = ~(one << ((k / 4) % 4));
      n_checks++;
      if (column_n !== exp_col) begin
        n_fail++;
        $display("FAIL column_seq[%0d]: got %b want %b", k, column_n, exp_col);
      end
      tick();
    end
    n_checks++;
    if ({key_valid, key_held, overflow, key_code} !== 7'b0) begin
      n_fail++;
      $display("FAIL idle_outputs: got v=%b h=%b o=%b code=%0d want all 0",
               key_valid, key_held, overflow, key_code);
    end
  endtask

  task automatic test_clean_press();
    int first;
    int drop;
    first = -1;
    drop  = -1;
    ev_q.delete();
    key_ready = 1'b1;
    keys_down = 16'h0200;
    for (int i = 0; i < 96; i++) begin
      tick();
      if (key_valid && first < 0) first = i;
    end
    n_checks++;
    if (first < 48 || first > 84) begin
      n_fail++;
      $display("FAIL press_latency: got %0d cycles want 48..84", first);
    end
    n_checks++;
    if (ev_q.size() !== 1 || ev_q[0] !== 4'd9) begin
      n_fail++;
      $display("FAIL press_event: got %0d events first=%0d want 1 event code 9",
               ev_q.size(), (ev_q.size() > 0) ? ev_q[0] : 4'hf);
    end
    n_checks++;
    if (key_held !== 1'b1) begin
      n_fail++;
      $display("FAIL press_held: got %b want 1", key_held);
    end
    keys_down = '0;
    for (int i = 0; i < 84; i++) begin
      tick();
      if (i == 31) begin
        n_checks++;
        if (key_held !== 1'b1) begin
          n_fail++;
          $display("FAIL release_early: key_held got %b want 1 after 2 frames", key_held);
        end
      end
      if (!key_held && drop < 0) drop = i;
    end
    n_checks++;
    if (drop < 0) begin
      n_fail++;
      $display("FAIL release_latency: key_held got 1 want 0 within 84 cycles");
    end
    wait_frames(2);
    n_checks++;
    if (ev_q.size() !== 1) begin
      n_fail++;
      $display("FAIL release_no_event: got %0d events want 1", ev_q.size());
    end
  endtask

  task automatic test_bounce();
    logic bad;
    bad = 1'b0;
    ev_q.delete();
    for (int f = 0; f < 6; f++) begin
      keys_down = (f % 2 == 0) ? 16'h0200 : 16'h0000;
      repeat (16) begin
        tick();
        if (key_held || key_valid) bad = 1'b1;
      end
    end
    n_checks++;
    if (bad !== 1'b0 || ev_q.size() !== 0) begin
      n_fail++;
      $display("FAIL bounce_quiet: got bad=%b events=%0d want 0 and 0", bad, ev_q.size());
    end
    keys_down = 16'h0200;
    wait_frames(6);
    n_checks++;
    if (ev_q.size() !== 1 || ev_q[0] !== 4'd9 || key_held !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_event: got events=%0d held=%b want 1 event code 9 held 1",
               ev_q.size(), key_held);
    end
    keys_down = '0;
    wait_frames(6);
    n_checks++;
    if (key_held !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_release: key_held got %b want 0", key_held);
    end
  endtask

  task automatic test_ghost();
    logic bad;
    bad = 1'b0;
    ev_q.delete();
    keys_down = 16'h0021;
    repeat (160) begin
      tick();
      if (key_held || key_valid) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0 || ev_q.size() !== 0) begin
      n_fail++;
      $display("FAIL ghost: got bad=%b events=%0d want 0 and 0", bad, ev_q.size());
    end
    keys_down = '0;
    wait_frames(2);
  endtask

  task automatic test_overflow();
    int         codes[5];
    logic [3:0] got;
    codes = '{1, 2, 3, 4, 6};
    key_ready = 1'b0;
    ev_q.delete();
    for (int i = 0; i < 5; i++) begin
      keys_down = 16'h0001 << codes[i];
      wait_frames(6);
      keys_down = '0;
      wait_frames(6);
      if (i == 3) begin
        n_checks++;
        if (overflow !== 1'b0 || key_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL fifo_full_no_overflow: got o=%b v=%b want o=0 v=1", overflow, key_valid);
        end
      end
    end
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set: got %b want 1", overflow);
    end
    n_checks++;
    if (key_code !== 4'd1) begin
      n_fail++;
      $display("FAIL overflow_head: got %0d want 1", key_code);
    end
    key_ready = 1'b1;
    repeat (8) tick();
    n_checks++;
    if (ev_q.size() !== 4) begin
      n_fail++;
      $display("FAIL drain_count: got %0d want 4", ev_q.size());
    end
    for (int j = 0; j < 4; j++) begin
      got = (j < ev_q.size()) ? ev_q[j] : 4'hf;
      n_checks++;
      if (got !== 4'(j + 1)) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: got %0d want %0d", j, got, j + 1);
      end
    end
    n_checks++;
    if (key_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_end: got v=%b o=%b want v=0 o=1", key_valid, overflow);
    end
  endtask

  task automatic test_reset_mid();
    key_ready = 1'b1;
    ev_q.delete();
    keys_down = 16'h0080;
    wait_frames(2);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({column_n, key_valid, key_held, overflow, key_code} !== 11'b1110_000_0000) begin
      n_fail++;
      $display("FAIL reset_mid_debounce: got col=%b v=%b h=%b o=%b code=%0d want 1110/0/0/0/0",
               column_n, key_valid, key_held, overflow, key_code);
    end
    keys_down = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    wait_frames(6);
    n_checks++;
    if (ev_q.size() !== 0 || key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: got events=%0d v=%b want 0 and 0", ev_q.size(), key_valid);
    end
    keys_down = 16'h0080;
    wait_frames(6);
    n_checks++;
    if (ev_q.size() !== 1 || ev_q[0] !== 4'd7 || key_held !== 1'b1) begin
      n_fail++;
      $display("FAIL fresh_press: got events=%0d held=%b want 1 event code 7 held 1",
               ev_q.size(), key_held);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({column_n, key_valid, key_held, overflow, key_code} !== 11'b1110_000_0000) begin
      n_fail++;
      $display("FAIL reset_mid_held: got col=%b v=%b h=%b o=%b code=%0d want 1110/0/0/0/0",
               column_n, key_valid, key_held, overflow, key_code);
    end
    repeat (3) tick();
    keys_down = '0;
    reset_n = 1'b1;
    wait_frames(6);
    n_checks++;
    if (ev_q.size() !== 1 || key_held !== 1'b0 || key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL after_held_reset: got events=%0d h=%b v=%b want 1/0/0",
               ev_q.size(), key_held, key_valid);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_ghost();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix keypad scanner and debouncer: the input-side counterpart of the multiplexed seven-segment display driver. It shares that driver's slow scan clock and strobes keypad columns one at a time, the same way the display strobes tube enables. It samples the row lines, debounces over whole scan frames, and delivers one key code per accepted press through a small valid/ready FIFO to the application logic.

## Interface
Parameters:
- row_number, 4, keypad rows
- column_number, 4, keypad columns
- column_dwell, 4, cycles each column is driven (must be ≥ 3)
- debounce_frames, 4, identical consecutive frames required to accept a press or release (must be ≥ 2)
- fifo_depth, 4, key event FIFO entries (power of 2)

Ports:
- clock_digital_tube  input  1  scan clock (already decided)
- reset_n  input  1  reset, asynchronous, active-low (already decided)
- row_n  input  row_number  raw row lines, pulled up, low = contact
- column_n  output  column_number  column strobes, exactly one low
- key_code  output  code_width  FIFO head code; code_width = $clog2(row_number*column_number)
- key_valid  output  1  FIFO not empty
- key_ready  input  1  consumer accepts head
- key_held  output  1  a debounced key is currently down
- overflow  output  1  sticky; set when a press is dropped on a full FIFO

## Operation
- row_n passes through a 2-flop synchronizer.
- The column index advances 0..column_number-1 and wraps. Each column is held for column_dwell cycles. column_n[i] = 0 only for the active column.
- Synchronized rows are sampled on the last dwell cycle of each column into a row_number×column_number frame snapshot.
- A frame is complete when the last column is sampled.
- Frame classification: none (0 bits set), single (exactly 1 bit set, at row r, column c, code = r*column_number + c), multi (≥2 bits set).
- The FSM updates once per completed frame; cnt is the frame counter.
  - IDLE: single k → candidate = k, cnt = 1, go to DEBOUNCE. none/multi → stay in IDLE.
  - DEBOUNCE:
    - single k matching the candidate → cnt+1; when cnt reaches debounce_frames, push k and go to HELD.
    - single k' ≠ candidate → candidate = k', cnt = 1.
    - none/multi → IDLE.
  - HELD: none → cnt = 1, go to RELEASE. single/multi → stay in HELD (no auto-repeat).
  - RELEASE: none → cnt+1; at debounce_frames go to IDLE. single/multi → HELD.
- key_held = state ∈ {HELD, RELEASE}.
- FIFO behaviour:
  - Push only on acceptance. Pop when key_valid && key_ready. key_code = head entry.
  - Push while full with no pop: the new code is dropped and overflow is set. Only reset clears overflow.
  - Push and pop in the same cycle while full: both take effect, and overflow is not set.
  - Push while empty: key_valid rises the next cycle (no bypass).

## Timing
- Reset values: column index 0, so column_n = all ones except bit 0. key_valid 0, key_code 0, key_held 0, overflow 0, state IDLE, all counters and FIFO pointers 0.
- Frame length is column_number*column_dwell cycles (16 by default).
- The push occurs on the cycle following the sample that completes the debounce_frames-th matching frame. key_valid follows one cycle after the push.
- Press-to-key_valid latency for a bounce-free press: at most (debounce_frames+1)*frame + 4 cycles.
- Release-to-key_held-low latency: at most (debounce_frames+1)*frame + 4 cycles.
- Reset asserted mid-operation returns every register to its reset value immediately. Partially debounced keys and FIFO contents are discarded.

## Structure
- keypad_pkg holds:
  - default constants for row_number and column_number
  - the code_width function/constant
  - the keypad_state_t enum {IDLE, DEBOUNCE, HELD, RELEASE}
  - the frame classification enum {NONE, SINGLE, MULTI}
- One sub-module, keypad_fifo: a parameterized synchronous FIFO with push, pop, full, empty and head outputs. The overflow logic stays in the top level.

## Test plan
Default parameters throughout.
- Reset check: after reset_n rises, column_n sequences 1110, 1101, 1011, 0111, each for 4 cycles, then repeats. All other outputs are 0.
- Clean press: pull row_n[2] low whenever column_n[1] = 0, for 6 frames, with key_ready = 1. Required: exactly one key_valid pulse with key_code = 9, and key_held = 1. After release, key_held = 0 within 5 frames + 4 cycles.
- Bounce: key 9 present on alternating frames for 3 frames, then stable. Required: exactly one event, code 9, and no event during the bounce.
- Ghost: codes 0 and 5 pressed together for 10 frames. Required: key_valid stays 0 and key_held stays 0.
- Overflow: key_ready = 0; press and release codes 1, 2, 3, 4, 6 in turn. Required: overflow = 1. Raising key_ready then yields 1, 2, 3, 4 in order, after which key_valid = 0.
- Reset mid-debounce (after 2 frames of key 7) and again mid-HELD. Required: all outputs return to their reset values, and no key_valid follows unless a fresh full debounce completes.
